clk_reset_gen: RTL and testbench
================================

Name: clk_reset_gen

Overview:
Parametrised successor to the fixed divide-by-2 clock and reset logic in the 8085 system top. Derives non-overlapping phi1/phi2 phases and clk_out from the x1 oscillator clock, with programmable period and dead time. Synchronises the external active-low resetn_in and sequences reset_out with a programmable hold stretch. Adds a clean clock-stop mode. Sits at the top of system and feeds the CPU core and its peripherals.

Parameters:
PERIOD, 2, x1 cycles per phase cycle; even, >=2
GAP, 0, dead x1 cycles at the end of each phase window; 0 <= GAP < PERIOD/2
SYNC_STAGES, 2, flops in the resetn_in synchroniser; >=2
RESET_HOLD, 3, phase cycles reset_out stays high after synced resetn_in returns high; >=1

Ports:
x1  input  1  master clock; all flops on the rising edge
reset  input  1  asynchronous, active-high master reset
resetn_in  input  1  external reset pin, active-low, asynchronous to x1
clock_stop  input  1  request to freeze phase clocks; honoured only in RUN
phi1  output  1  phase-1 clock, registered
phi2  output  1  phase-2 clock, registered
clk_out  output  1  external clock, registered
reset_out  output  1  system reset, active-high, registered
stopped  output  1  high while phase clocks are frozen

Behaviour:
- Async reset: cnt = PERIOD-1; phi1, phi2, clk_out, stopped = 0; reset_out = 1; synchroniser flops = 0; FSM = ASSERT; hold_cnt = 0.
- Counter cnt is $clog2(PERIOD) bits wide. Each edge: cnt_n = (cnt == PERIOD-1) ? 0 : cnt+1. A boundary is an edge where cnt wraps from PERIOD-1 to 0.
- Outputs are registered decodes of cnt_n:
  - phi1 = cnt_n < PERIOD/2-GAP
  - phi2 = PERIOD/2 <= cnt_n < PERIOD-GAP
  - clk_out = cnt_n >= PERIOD/2
  - phi1 and phi2 are never high together.
- First edge after reset release: cnt = 0, phi1 = 1.
- Synchroniser output s = last of SYNC_STAGES flops clocked by x1, with resetn_in as input. A one-cycle low is captured, not filtered.
- FSM ASSERT:
  - reset_out = 1.
  - Moves to HOLD on a boundary edge with s = 1; loads hold_cnt = RESET_HOLD.
  - hold_cnt is $clog2(RESET_HOLD+1) bits wide.
- FSM HOLD:
  - reset_out = 1; hold_cnt decrements on each boundary.
  - On the boundary where hold_cnt == 1, moves to RUN and reset_out falls at that edge.
- FSM RUN: reset_out = 0.
- Reset re-entry: s = 0 in HOLD or RUN moves to ASSERT on the next edge, not boundary-aligned; reset_out rises at that edge. s = 0 in ASSERT keeps ASSERT.
- Clock stop: in RUN, at an edge with cnt == PERIOD-1 and clock_stop = 1:
  - cnt holds at PERIOD-1; phi1, phi2, clk_out <= 0; stopped <= 1.
  - Stays frozen while clock_stop = 1.
  - First edge with clock_stop = 0: cnt wraps to 0, phi1 = 1, stopped = 0.
- clock_stop is ignored in ASSERT and HOLD. If s = 0 while stopped: FSM goes to ASSERT, clocks resume at the same edge (cnt wraps to 0), stopped = 0.
- Phase clocks keep running through ASSERT and HOLD.

Test Plan:
1. Defaults, reset released, resetn_in = 1 from t0 -> phi1 = 1,0,1,0... and phi2 = ~phi1 from the first edge; clk_out == phi2; phi1 & phi2 never 1.
2. PERIOD=4, GAP=1 -> per 4 cycles: phi1 = 1000, phi2 = 0010, clk_out = 0011; pattern repeats without drift over 100 periods.
3. Defaults, resetn_in rises at edge E -> s high at E+2; ASSERT->HOLD at the next boundary B; reset_out falls exactly at B+6 x1 edges (3 boundaries).
4. In RUN, resetn_in pulsed low for one x1 cycle -> reset_out rises 3 edges later, then full HOLD sequence repeats; phi1/phi2 never pause.
5. PERIOD=4, in RUN, clock_stop = 1 for 10 cycles -> freeze at cnt = 3, all phases 0, stopped = 1. On release, phi1 = 1 on the next edge. Same request during HOLD -> ignored, HOLD completes on schedule.
6. Assert reset mid-RUN with phi2 high -> outputs reach reset values immediately, without waiting for an x1 edge. After release, the step 3 sequence is reproduced.

Source files
------------

// File: rtl/clk_reset_gen_if.sv
// Signal bundle between the clock/reset generator and the system it drives.
// The master side is the generator; the slave side is the CPU/peripheral side.
interface clk_reset_gen_if;
  logic resetn_in;
  logic clock_stop;
  logic phi1;
  logic phi2;
  logic clk_out;
  logic reset_out;
  logic stopped;

  modport master (
    input  resetn_in, clock_stop,
    output phi1, phi2, clk_out, reset_out, stopped
  );

  modport slave (
    output resetn_in, clock_stop,
    input  phi1, phi2, clk_out, reset_out, stopped
  );
endinterface

// File: rtl/clk_reset_gen.sv
// Two-phase non-overlapping clock generator with synchronised, stretched system
// reset and a clean clock-stop mode, all clocked from the x1 oscillator.
module clk_reset_gen #(
  parameter int PERIOD      = 2,
  parameter int GAP         = 0,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_HOLD  = 3
) (
  input  logic             x1,
  input  logic             reset,
  clk_reset_gen_if.master  bus
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HW = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  // Decode thresholds carry one extra bit so PERIOD itself is representable.
  localparam logic [CW:0]   P1_END = (CW+1)'(PERIOD / 2 - GAP);
  localparam logic [CW:0]   HALF   = (CW+1)'(PERIOD / 2);
  localparam logic [CW:0]   P2_END = (CW+1)'(PERIOD - GAP);

  typedef enum logic [1:0] {ST_ASSERT, ST_HOLD, ST_RUN} state_t;

  state_t                 state, state_n;
  logic [HW-1:0]          hold_cnt, hold_n;
  logic                   reset_nxt;
  logic [CW-1:0]          cnt, cnt_n;
  logic [CW:0]            cnt_w;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, wrap, freeze, boundary;

  // resetn_in synchroniser; a single low cycle still propagates through
  always_ff @(posedge x1 or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.resetn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    wrap     = (cnt == LAST);
    freeze   = (state == ST_RUN) && wrap && bus.clock_stop && s;
    boundary = wrap && !freeze;
    cnt_n    = freeze ? cnt : (wrap ? '0 : cnt + CW'(1));
    cnt_w    = {1'b0, cnt_n};
  end

  always_ff @(posedge x1 or posedge reset) begin
    if (reset) begin
      cnt         <= LAST;
      bus.phi1    <= 1'b0;
      bus.phi2    <= 1'b0;
      bus.clk_out <= 1'b0;
      bus.stopped <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      bus.phi1    <= !freeze && (cnt_w < P1_END);
      bus.phi2    <= !freeze && (cnt_w >= HALF) && (cnt_w < P2_END);
      bus.clk_out <= !freeze && (cnt_w >= HALF);
      bus.stopped <= freeze;
    end
  end

  // Reset sequencer: state register
  always_ff @(posedge x1 or posedge reset) begin
    if (reset) begin
      state         <= ST_ASSERT;
      hold_cnt      <= '0;
      bus.reset_out <= 1'b1;
    end else begin
      state         <= state_n;
      hold_cnt      <= hold_n;
      bus.reset_out <= reset_nxt;
    end
  end

  // Reset sequencer: next state; a low synchroniser output wins over any boundary
  always_comb begin
    state_n = state;
    case (state)
      ST_ASSERT: if (boundary && s) state_n = ST_HOLD;
      ST_HOLD: begin
        if (!s)                                   state_n = ST_ASSERT;
        else if (boundary && hold_cnt == HW'(1))  state_n = ST_RUN;
      end
      ST_RUN:    if (!s) state_n = ST_ASSERT;
      default:   state_n = ST_ASSERT;
    endcase
  end

  // Reset sequencer: outputs, registered so reset_out moves on the transition edge
  always_comb begin
    hold_n    = hold_cnt;
    reset_nxt = (state_n != ST_RUN);
    case (state)
      ST_ASSERT: if (state_n == ST_HOLD) hold_n = HW'(RESET_HOLD);
      ST_HOLD:   if (s && boundary)      hold_n = hold_cnt - HW'(1);
      default:   hold_n = hold_cnt;
    endcase
  end

endmodule

// File: tb/tb_clk_reset_gen.sv
// Directed bench: default-parameter instance (a) and PERIOD=4/GAP=1 instance (b)
// sharing x1 and reset, checked edge by edge against hand-derived schedules.
module tb_clk_reset_gen;

  logic x1;
  logic reset;
  int   vecs = 0;
  int   errs = 0;
  int   e    = 0;

  clk_reset_gen_if ifa ();
  clk_reset_gen_if ifb ();

  clk_reset_gen dut_a (.x1(x1), .reset(reset), .bus(ifa));
  clk_reset_gen #(.PERIOD(4), .GAP(1), .SYNC_STAGES(2), .RESET_HOLD(3))
    dut_b (.x1(x1), .reset(reset), .bus(ifb));

  initial x1 = 1'b0;
  always #5 x1 = ~x1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s edge %0d: got %b want %b", tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge x1);
    #2;
    e++;
  endtask

  // Instance a (PERIOD=2): odd edges leave cnt=0 -> phi1, even edges cnt=1 -> phi2/clk_out
  task automatic chk_a();
    chk("a_phi1", ifa.phi1, (e % 2) == 1);
    chk("a_phi2", ifa.phi2, (e % 2) == 0);
    chk("a_clk_out", ifa.clk_out, (e % 2) == 0);
    chk("a_overlap", ifa.phi1 & ifa.phi2, 1'b0);
  endtask

  // Instance b (PERIOD=4, GAP=1): phi1=1000, phi2=0010, clk_out=0011 from edge 1
  task automatic chk_b(input logic frozen);
    int idx;
    idx = (e - 1) % 4;
    if (frozen) begin
      chk("b_phi1_frz", ifb.phi1, 1'b0);
      chk("b_phi2_frz", ifb.phi2, 1'b0);
      chk("b_clk_frz", ifb.clk_out, 1'b0);
      chk("b_stopped_frz", ifb.stopped, 1'b1);
    end else begin
      chk("b_phi1", ifb.phi1, idx == 0);
      chk("b_phi2", ifb.phi2, idx == 2);
      chk("b_clk_out", ifb.clk_out, idx >= 2);
      chk("b_stopped", ifb.stopped, 1'b0);
    end
    chk("b_overlap", ifb.phi1 & ifb.phi2, 1'b0);
  endtask

  // Enters with reset high and resetn_in low. resetn_in rises after edge 4,
  // s is high after edge 6; a enters HOLD at boundary 7 and runs at 13,
  // b enters HOLD at boundary 9 and runs at 21. b.clock_stop is held high
  // during its HOLD window and must be ignored.
  task automatic bringup();
    @(negedge x1);
    reset = 1'b0;
    e = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      chk_a();
      chk_b(1'b0);
      chk("a_reset_out", ifa.reset_out, e < 13);
      chk("b_reset_out", ifb.reset_out, e < 21);
      chk("a_stopped", ifa.stopped, 1'b0);
      if (e == 4) begin
        ifa.resetn_in = 1'b1;
        ifb.resetn_in = 1'b1;
      end
      if (e == 8)  ifb.clock_stop = 1'b1;
      if (e == 20) ifb.clock_stop = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_phi1"}, ifa.phi1, 1'b0);
    chk({tag, "_a_phi2"}, ifa.phi2, 1'b0);
    chk({tag, "_a_clk"}, ifa.clk_out, 1'b0);
    chk({tag, "_a_rst"}, ifa.reset_out, 1'b1);
    chk({tag, "_a_stp"}, ifa.stopped, 1'b0);
    chk({tag, "_b_phi1"}, ifb.phi1, 1'b0);
    chk({tag, "_b_clk"}, ifb.clk_out, 1'b0);
    chk({tag, "_b_rst"}, ifb.reset_out, 1'b1);
  endtask

  initial begin
    reset          = 1'b1;
    ifa.resetn_in  = 1'b0;
    ifb.resetn_in  = 1'b0;
    ifa.clock_stop = 1'b0;
    ifb.clock_stop = 1'b0;
    #3;
    chk_reset_vals("rst0");
    repeat (2) @(posedge x1);

    // Bring-up: phase pattern from edge 1, reset_out release timing, stop ignored in HOLD
    bringup();

    // Long run: no drift over 100 periods of b
    for (int k = 0; k < 400; k++) begin
      step();
      chk_a();
      chk_b(1'b0);
    end
    chk("a_run_rst", ifa.reset_out, 1'b0);
    chk("b_run_rst", ifb.reset_out, 1'b0);

    // Clock stop on b in RUN: request after edge 426 (cnt=1); freeze at edges 429..436
    step();
    step();
    ifb.clock_stop = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step();
      chk_a();
      chk_b(e >= 429 && e <= 436);
      chk("b_rst_stop", ifb.reset_out, 1'b0);
      if (e == 436) ifb.clock_stop = 1'b0;
    end
    chk("b_resume_phi1", ifb.phi1, 1'b1);

    // One-cycle resetn_in glitch on a in RUN after edge 438:
    // reset_out high at 441..448, HOLD from boundary 443, released at 449
    step();
    ifa.resetn_in = 1'b0;
    step();
    ifa.resetn_in = 1'b1;
    chk_a();
    chk("a_glitch_rst", ifa.reset_out, 1'b0);
    for (int k = 0; k < 13; k++) begin
      step();
      chk_a();
      chk_b(1'b0);
      chk("a_glitch_rst", ifa.reset_out, e >= 441 && e <= 448);
    end

    // Async reset mid-RUN with a.phi2 high (e=452 is even)
    chk("a_pre_phi2", ifa.phi2, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    ifa.resetn_in = 1'b0;
    ifb.resetn_in = 1'b0;
    repeat (2) @(posedge x1);
    chk_reset_vals("held");

    // Same bring-up sequence again after the mid-run reset
    bringup();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
